// File: rtl/param_scan_counter_pkg.sv
// Shared types and helpers for the param_scan_counter slice: per-edge
// priority mode and scan chain geometry.
package param_scan_counter_pkg;

  // Per-edge operating mode, listed in priority order.
  typedef enum logic [1:0] {
    MODE_SHIFT = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  // Number of counter bits carried by each scan chain (the last chain also
  // carries the wrap flop on top of this).
  function automatic int chain_len(input int width, input int num_chains);
    return width / num_chains;
  endfunction

endpackage

// File: rtl/param_scan_counter_if.sv
// Control, scan and result signals of param_scan_counter bundled as one
// interface; master drives stimulus, slave is the counter.
interface param_scan_counter_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_CHAINS = 2
);

  logic                  scan_en;
  logic [NUM_CHAINS-1:0] scan_in;
  logic [NUM_CHAINS-1:0] scan_out;
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      q;
  logic                  tc;
  logic                  wrap;

  modport master (
    output scan_en, scan_in, en, up_dn, load, load_val,
    input  scan_out, q, tc, wrap
  );

  modport slave (
    input  scan_en, scan_in, en, up_dn, load, load_val,
    output scan_out, q, tc, wrap
  );

endinterface

// File: rtl/param_scan_counter_cell.sv
// scan_cell_n: one mux-D scan flop with asynchronous active-low reset to a
// per-instance reset value.
module scan_cell_n #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scan_en,
  input  logic scan_in,
  input  logic d,
  output logic q
);

  logic d_mux_s;

  // Scan mux: shift path wins over the functional next state.
  always_comb begin
    d_mux_s = d;
    if (scan_en) begin
      d_mux_s = scan_in;
    end else begin
      d_mux_s = d;
    end
  end

  // State flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d_mux_s;
    end
  end

endmodule

// File: rtl/param_scan_counter.sv
// Parametrised up/down counter with load, terminal count and sticky wrap flag;
// all flops sit on NUM_CHAINS mux-D scan chains, the wrap flop ending the last.
// Optional build macro PARAM_SCAN_COUNTER_SATURATE_EN: saturate instead of wrap.
module param_scan_counter
  import param_scan_counter_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               NUM_CHAINS = 2,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  param_scan_counter_if.slave  bus
);

  localparam int               L   = chain_len(WIDTH, NUM_CHAINS);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 2) begin : g_bad_width
    $error("param_scan_counter: WIDTH must be at least 2");
  end
  if ((WIDTH % NUM_CHAINS) != 0) begin : g_bad_chains
    $error("param_scan_counter: WIDTH must be a multiple of NUM_CHAINS");
  end

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_q_s;
  logic             next_wrap_s;
  logic [WIDTH-1:0] shift_in_s;
  mode_e            mode_s;
  logic             at_max_s;
  logic             at_min_s;
  logic             tc_s;

  assign at_max_s = &q_r;
  assign at_min_s = ~|q_r;

  // Resolve the per-edge priority: scan, then load, then count, else hold.
  always_comb begin
    mode_s = MODE_HOLD;
    if (bus.scan_en) begin
      mode_s = MODE_SHIFT;
    end else if (bus.load) begin
      mode_s = MODE_LOAD;
    end else if (bus.en) begin
      mode_s = MODE_COUNT;
    end else begin
      mode_s = MODE_HOLD;
    end
  end

  // Functional next state; shifting is handled by the scan mux in each cell.
  always_comb begin
    next_q_s    = q_r;
    next_wrap_s = wrap_r;
    case (mode_s)
      MODE_LOAD: begin
        next_q_s    = bus.load_val;
        next_wrap_s = 1'b0;
      end
      MODE_COUNT: begin
        if (bus.up_dn) begin
          if (at_max_s) begin
            next_wrap_s = 1'b1;
`ifdef PARAM_SCAN_COUNTER_SATURATE_EN
            next_q_s    = q_r;
`else
            next_q_s    = {WIDTH{1'b0}};
`endif
          end else begin
            next_q_s = q_r + ONE;
          end
        end else begin
          if (at_min_s) begin
            next_wrap_s = 1'b1;
`ifdef PARAM_SCAN_COUNTER_SATURATE_EN
            next_q_s    = q_r;
`else
            next_q_s    = {WIDTH{1'b1}};
`endif
          end else begin
            next_q_s = q_r - ONE;
          end
        end
      end
      MODE_SHIFT: begin
        next_q_s    = q_r;
        next_wrap_s = wrap_r;
      end
      MODE_HOLD: begin
        next_q_s    = q_r;
        next_wrap_s = wrap_r;
      end
      default: begin
        next_q_s    = q_r;
        next_wrap_s = wrap_r;
      end
    endcase
  end

  // Chain heads take scan_in; every other bit takes its lower neighbour.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain_in
    if ((i % L) == 0) begin : g_head
      assign shift_in_s[i] = bus.scan_in[i / L];
    end else begin : g_body
      assign shift_in_s[i] = q_r[i-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_q_cell
    scan_cell_n #(
      .RST_VAL (RESET_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst_n   (reset),
      .scan_en (bus.scan_en),
      .scan_in (shift_in_s[i]),
      .d       (next_q_s[i]),
      .q       (q_r[i])
    );
  end

  scan_cell_n #(
    .RST_VAL (1'b0)
  ) u_wrap_cell (
    .clk     (clk),
    .rst_n   (reset),
    .scan_en (bus.scan_en),
    .scan_in (q_r[WIDTH-1]),
    .d       (next_wrap_s),
    .q       (wrap_r)
  );

  // Chain tails; the last chain ends in the wrap flop rather than q[WIDTH-1].
  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_scan_out
    if (c == NUM_CHAINS - 1) begin : g_last
      assign bus.scan_out[c] = wrap_r;
    end else begin : g_mid
      assign bus.scan_out[c] = q_r[c*L + L - 1];
    end
  end

  assign tc_s = bus.en & ~bus.scan_en & ~bus.load & (bus.up_dn ? at_max_s : at_min_s);

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.tc   = tc_s;

endmodule

// File: tb/tb_param_scan_counter.sv
// Randomised self-checking bench for param_scan_counter: two instances
// (2 chains / reset 00, 4 chains / reset A5) against an arithmetic model.
module tb_param_scan_counter;

  localparam int W = 8;

  logic clk;
  logic reset;

  param_scan_counter_if #(.WIDTH(W), .NUM_CHAINS(2)) bus_a ();
  param_scan_counter_if #(.WIDTH(W), .NUM_CHAINS(4)) bus_b ();

  param_scan_counter #(.WIDTH(W), .NUM_CHAINS(2), .RESET_VAL(8'h00)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  param_scan_counter #(.WIDTH(W), .NUM_CHAINS(4), .RESET_VAL(8'hA5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic         s_scan_en;
  logic         s_load;
  logic         s_en;
  logic         s_up;
  logic [W-1:0] s_lv;
  logic [1:0]   sin_a;
  logic [3:0]   sin_b;

  int mq   [2];
  int mw   [2];
  int nc_m [2] = '{2, 4};
  int rv_m [2] = '{0, 165};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: observed %0h, expected %0h", tag, act, expv);
    end
  endtask

  function automatic int exp_tc(input int k);
    if (s_scan_en || s_load || !s_en) return 0;
    if (s_up) return (mq[k] == 255) ? 1 : 0;
    return (mq[k] == 0) ? 1 : 0;
  endfunction

  function automatic int exp_so(input int k);
    int l;
    int so;
    l  = W / nc_m[k];
    so = 0;
    for (int c = 0; c < nc_m[k] - 1; c++) begin
      so = so | (((mq[k] >> (c*l + l - 1)) & 1) << c);
    end
    so = so | (mw[k] << (nc_m[k] - 1));
    return so;
  endfunction

  task automatic model_edge(input int k, input int sin);
    int l;
    int nq;
    int nw;
    int seg;
    l = W / nc_m[k];
    if (s_scan_en) begin
      nq = 0;
      nw = (mq[k] >> (W - 1)) & 1;
      for (int c = 0; c < nc_m[k]; c++) begin
        seg = (mq[k] >> (c*l)) & ((1 << l) - 1);
        seg = ((seg << 1) | ((sin >> c) & 1)) & ((1 << l) - 1);
        nq  = nq | (seg << (c*l));
      end
      mq[k] = nq;
      mw[k] = nw;
    end else if (s_load) begin
      mq[k] = int'(s_lv);
      mw[k] = 0;
    end else if (s_en) begin
      if (s_up && mq[k] == 255) begin
        mw[k] = 1;
`ifdef PARAM_SCAN_COUNTER_SATURATE_EN
        mq[k] = 255;
`else
        mq[k] = 0;
`endif
      end else if (!s_up && mq[k] == 0) begin
        mw[k] = 1;
`ifdef PARAM_SCAN_COUNTER_SATURATE_EN
        mq[k] = 0;
`else
        mq[k] = 255;
`endif
      end else begin
        mq[k] = s_up ? mq[k] + 1 : mq[k] - 1;
      end
    end
  endtask

  task automatic drive();
    bus_a.scan_en  = s_scan_en;
    bus_a.load     = s_load;
    bus_a.en       = s_en;
    bus_a.up_dn    = s_up;
    bus_a.load_val = s_lv;
    bus_a.scan_in  = sin_a;
    bus_b.scan_en  = s_scan_en;
    bus_b.load     = s_load;
    bus_b.en       = s_en;
    bus_b.up_dn    = s_up;
    bus_b.load_val = s_lv;
    bus_b.scan_in  = sin_b;
  endtask

  task automatic check_state();
    check_val("q_a", 32'(bus_a.q), mq[0]);
    check_val("wrap_a", 32'(bus_a.wrap), mw[0]);
    check_val("q_b", 32'(bus_b.q), mq[1]);
    check_val("wrap_b", 32'(bus_b.wrap), mw[1]);
  endtask

  // One clock: check the combinational outputs, take the edge, check state.
  task automatic cycle();
    drive();
    #1;
    check_val("tc_a", 32'(bus_a.tc), exp_tc(0));
    check_val("tc_b", 32'(bus_b.tc), exp_tc(1));
    check_val("so_a", 32'(bus_a.scan_out), exp_so(0));
    check_val("so_b", 32'(bus_b.scan_out), exp_so(1));
    @(posedge clk);
    model_edge(0, 32'(sin_a));
    model_edge(1, 32'(sin_b));
    #1;
    check_state();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      mq[k] = rv_m[k];
      mw[k] = 0;
    end
    check_state();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [4:0] seq0;
    reset     = 1'b1;
    s_scan_en = 1'b0;
    s_load    = 1'b0;
    s_en      = 1'b0;
    s_up      = 1'b0;
    s_lv      = 8'h00;
    sin_a     = 2'b00;
    sin_b     = 4'b0000;
    drive();
    @(posedge clk);
    #1;
    do_reset();

    // Load FE then count up across the top.
    s_load = 1'b1;
    s_lv   = 8'hFE;
    cycle();
    s_load = 1'b0;
    s_en   = 1'b1;
    s_up   = 1'b1;
    repeat (3) cycle();
`ifdef PARAM_SCAN_COUNTER_SATURATE_EN
    check_val("up_end_q", 32'(bus_a.q), 32'h0000_00FF);
`else
    check_val("up_end_q", 32'(bus_a.q), 32'h0000_0001);
`endif
    check_val("up_end_wrap", 32'(bus_a.wrap), 32'h0000_0001);

    // Reset mid-count with wrap set, then count down from zero.
    do_reset();
    s_up = 1'b0;
    cycle();
`ifdef PARAM_SCAN_COUNTER_SATURATE_EN
    check_val("dn_q", 32'(bus_a.q), 32'h0000_0000);
`else
    check_val("dn_q", 32'(bus_a.q), 32'h0000_00FF);
`endif
    check_val("dn_wrap", 32'(bus_a.wrap), 32'h0000_0001);
    s_en   = 1'b0;
    s_load = 1'b1;
    s_lv   = 8'h10;
    cycle();
    check_val("load_clr_wrap", 32'(bus_a.wrap), 32'h0000_0000);

    // Five shifts from reset: chain 0 gets 1,0,1,1,0, chain 1 all ones.
    do_reset();
    s_load    = 1'b0;
    s_scan_en = 1'b1;
    seq0      = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      sin_a = {1'b1, seq0[i]};
      cycle();
    end
    check_val("shift_lo", 32'(bus_a.q[3:0]), 32'h0000_0006);
    check_val("shift_hi", 32'(bus_a.q[7:4]), 32'h0000_000F);
    check_val("shift_wrap", 32'(bus_a.wrap), 32'h0000_0001);

    // Four-chain instance: reset to A5 then two all-zero shifts.
    do_reset();
    sin_a = 2'b00;
    sin_b = 4'b0000;
    repeat (2) cycle();
    check_val("b_shift_q", 32'(bus_b.q), 32'h0000_0000);

    // Shift wins over load and enable.
    s_load = 1'b1;
    s_en   = 1'b1;
    s_lv   = 8'h5A;
    sin_a  = 2'b10;
    cycle();
    check_val("shift_over_load", 32'(bus_a.q), 32'h0000_0010);

    // Random traffic, biased towards the count limits.
    for (int i = 0; i < 400; i++) begin
      s_scan_en = ($urandom_range(7, 0) == 0);
      s_load    = ($urandom_range(7, 0) == 0);
      s_en      = ($urandom_range(3, 0) != 0);
      s_up      = 1'($urandom);
      sin_a     = 2'($urandom);
      sin_b     = 4'($urandom);
      case ($urandom_range(3, 0))
        0:       s_lv = 8'h00;
        1:       s_lv = 8'hFF;
        default: s_lv = 8'($urandom);
      endcase
      if ($urandom_range(63, 0) == 0) begin
        do_reset();
      end
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
